panda_alu_arbiter: RTL and testbench
====================================

# panda_alu_arbiter

Shares one combinational `panda_alu` instance between `NumReq` requesters, e.g. the execute stage and the branch unit. Selection is round-robin with valid/ready handshakes. Each granted request drives the ALU in its accept cycle. The result is tagged with the requester index and pushed into a small response FIFO, which drains through a valid/ready response channel. The block sits between the decode/issue logic and the ALU and is the only driver of the ALU's inputs.

## Interface
- `NumReq`, default 2: number of requesters; legal range 2..8.
- `RspDepth`, default 2: response FIFO depth in entries; legal range 1..4.
- `IdW`, derived: `$clog2(NumReq)`.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  NumReq  per-requester request valid.
- `req_ready_o`  out  NumReq  per-requester accept; at most one bit high.
- `req_operator_i`  in  NumReq x alu_operator_e  per-requester operator.
- `req_operand_a_i`  in  NumReq x 32  per-requester operand A.
- `req_operand_b_i`  in  NumReq x 32  per-requester operand B.
- `rsp_valid_o`  out  1  FIFO head valid.
- `rsp_ready_i`  in  1  consumer accepts head.
- `rsp_id_o`  out  IdW  requester index of the head entry.
- `rsp_result_o`  out  32  ALU result of the head entry.
- `alu_operator_o`  out  alu_operator_e  to `panda_alu`.
- `alu_operand_a_o`  out  32  to `panda_alu`.
- `alu_operand_b_o`  out  32  to `panda_alu`.
- `alu_result_i`  in  32  from `panda_alu`; combinational in the same cycle.

## Operation
- **State:** priority pointer `prio` (IdW bits), FIFO storage of `RspDepth` x {id, result}, read/write pointers, and `count` (0..RspDepth).
- **Space check:** `space = (count < RspDepth)`. There is no pass-through: a pop in the same cycle does not create space for a push in that cycle.
- **Grant:** when `space` is 1, grant goes to the first requester with `req_valid_i` high, searching upward from `prio` and wrapping at `NumReq-1` to 0.
  - `req_ready_o[g]` = 1 for the granted index only; all other ready bits are 0.
  - If `space` is 0 or no request is valid, all ready bits are 0.
- **ALU drive:** while a grant is active, the `alu_*_o` outputs carry the granted requester's operator and operands. With no grant they carry `ALU_ADD`, 0 and 0.
- **Accept:** on a handshake (`valid & ready`) at requester g:
  - push {g, `alu_result_i`} into the FIFO;
  - set `prio <= (g == NumReq-1) ? 0 : g+1`.
- **Pointer hold:** `prio` is unchanged in any cycle without an accept.
- **Pop:** when `rsp_valid_o & rsp_ready_i`, the read pointer advances. `count` tracks +push −pop, so a simultaneous push and pop leaves `count` unchanged.
- **Response outputs:** `rsp_valid_o = (count != 0)`. `rsp_id_o` and `rsp_result_o` present the head entry directly from storage.
- **Pointer wrap:** the read and write pointers wrap modulo `RspDepth`. Non-power-of-two depths are handled by explicit compare-and-reset.
- **Requester-side rules:**
  - A requester must hold valid and payload stable until accepted.
  - The arbiter keeps no memory of a pending grant; it re-evaluates every cycle.
- **Reset behaviour:** reset clears `prio`, the pointers and `count`. FIFO data is not reset.
  - Reset asserted mid-operation discards all buffered responses.
  - During any cycle with `rst_i` high, `req_ready_o` = 0, and no push or pop takes effect.

## Timing
- **Reset values:** `req_ready_o` = 0, `rsp_valid_o` = 0, `rsp_id_o`/`rsp_result_o` = don't-care (X permitted), `alu_operator_o` = `ALU_ADD`, `alu_operand_*_o` = 0.
- **Request path:** `req_ready_o` is combinational from `req_valid_i`, `prio` and `count`. It does not depend on `rsp_ready_i`.
- **Latency:** a request accepted in cycle N appears as `rsp_valid_o` = 1 in cycle N+1 if the FIFO was empty.
- **Throughput:** one accept per cycle while the consumer holds `rsp_ready_i` = 1 and `RspDepth` ≥ 2. With `RspDepth` = 1, throughput is one accept every 2 cycles.
- **Fairness:** under continuous contention, each valid requester is granted within `NumReq` accepts.
- **Combinational path:** the critical path is request mux → ALU → FIFO write. There are no combinational paths from `rsp_ready_i` to any output.

## Test plan
- **Reset:** hold `rst_i` for 3 cycles while all `req_valid_i` = 1 → `req_ready_o` = 0 and `rsp_valid_o` = 0 throughout. The first grant after reset goes to requester 0.
- **Single request:** req0 = `ALU_SUB`, a = 5, b = 7, accepted in cycle N → in cycle N+1, `rsp_valid_o` = 1, id = 0, result = 0xFFFFFFFE.
- **Round-robin:** both requesters valid continuously, `rsp_ready_i` = 1, `RspDepth` = 2 → grants alternate 0, 1, 0, 1. Responses appear in order with matching ids. Req1 = `ALU_SLL`, a = 1, b = 31 yields 0x80000000.
- **Full FIFO:** `rsp_ready_i` = 0 and 3 back-to-back requests (`RspDepth` = 2) → 2 accepts, then `req_ready_o` = 0. Raising `rsp_ready_i` pops the first entry, and the third request is accepted in the cycle after the pop, not the same cycle.
- **Simultaneous push/pop at count = 1:** `count` stays at 1, pointers wrap correctly over 10 iterations, and ids and results match a scoreboard. Include the compare ops `ALU_LT` with a = 0xFFFFFFFF, b = 1 → 1, and `ALU_LTU` with the same operands → 0.
- **Reset mid-operation:** assert `rst_i` with 2 entries buffered → next cycle `rsp_valid_o` = 0. Buffered entries are never presented, and `prio` returns to 0.

Source files
------------

// File: rtl/panda_alu_arbiter.sv
// panda_alu_arbiter
//   Shares one combinational ALU between NumReq requesters. A round-robin
//   grant picks one valid requester per cycle. That requester's operator and
//   operands drive the ALU in the same cycle. The ALU result, tagged with the
//   requester index, is written into a small response FIFO. The FIFO drains
//   through a valid/ready response channel.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   per-requester handshake (ready is one-hot or zero)
//   req_operator_i        NumReq x OpW, packed with requester 0 in the low bits
//   req_operand_a_i/b_i   NumReq x 32, packed with requester 0 in the low bits
//   rsp_valid_o/ready_i   response handshake for the FIFO head
//   rsp_id_o/result_o     requester index and ALU result of the FIFO head
//   alu_operator_o        operator to the shared ALU
//   alu_operand_a_o/b_o   operands to the shared ALU
//   alu_result_i          combinational result returned by the shared ALU
module panda_alu_arbiter #(
  parameter int NumReq   = 2,
  parameter int RspDepth = 2,
  parameter int OpW      = 4,
  parameter int IdW      = $clog2(NumReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumReq-1:0]     req_valid_i,
  output logic [NumReq-1:0]     req_ready_o,
  input  logic [NumReq*OpW-1:0] req_operator_i,
  input  logic [NumReq*32-1:0]  req_operand_a_i,
  input  logic [NumReq*32-1:0]  req_operand_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IdW-1:0]        rsp_id_o,
  output logic [31:0]           rsp_result_o,
  output logic [OpW-1:0]        alu_operator_o,
  output logic [31:0]           alu_operand_a_o,
  output logic [31:0]           alu_operand_b_o,
  input  logic [31:0]           alu_result_i
);
  localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int CntW = $clog2(RspDepth + 1);

  localparam logic [OpW-1:0]  ALU_ADD   = '0;
  localparam logic [IdW-1:0]  LAST_ID   = IdW'(NumReq - 1);
  localparam logic [PtrW-1:0] LAST_PTR  = PtrW'(RspDepth - 1);
  localparam logic [CntW-1:0] DEPTH_C   = CntW'(RspDepth);
  localparam logic [IdW:0]    NUM_REQ_C = (IdW + 1)'(NumReq);

  logic [IdW-1:0]  prio_q, prio_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdW-1:0]  mem_id_q  [RspDepth];
  logic [IdW-1:0]  mem_id_d  [RspDepth];
  logic [31:0]     mem_res_q [RspDepth];
  logic [31:0]     mem_res_d [RspDepth];

  logic [IdW:0]    cand;
  logic            gnt_found;
  logic [IdW-1:0]  gnt_idx;
  logic            space;
  logic            push;
  logic            pop;

  // Round-robin search: walk upward from prio and wrap. The candidate gets
  // one spare bit so that prio + offset cannot overflow before the wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, prio_q} + (IdW + 1)'(i);
      if (cand >= NUM_REQ_C) cand = cand - NUM_REQ_C;
      if (!gnt_found && req_valid_i[cand[IdW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IdW-1:0];
      end
    end
  end

  // Space uses the count at the start of the cycle. A pop in the same cycle
  // does not make room, so rsp_ready_i never reaches the request side.
  assign space = (cnt_q < DEPTH_C);
  assign push  = gnt_found & space & ~rst_i;
  assign pop   = rsp_valid_o & rsp_ready_i & ~rst_i;

  always_comb begin
    req_ready_o     = '0;
    alu_operator_o  = ALU_ADD;
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    if (push) req_ready_o[gnt_idx] = 1'b1;
    for (int i = 0; i < NumReq; i++) begin
      if (push && (gnt_idx == IdW'(i))) begin
        alu_operator_o  = req_operator_i[i*OpW +: OpW];
        alu_operand_a_o = req_operand_a_i[i*32 +: 32];
        alu_operand_b_o = req_operand_b_i[i*32 +: 32];
      end
    end
  end

  // FIFO storage holds data only and is not reset; count and pointers
  // decide what is valid.
  always_comb begin
    mem_id_d  = mem_id_q;
    mem_res_d = mem_res_q;
    if (push) begin
      mem_id_d[wptr_q]  = gnt_idx;
      mem_res_d[wptr_q] = alu_result_i;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_id_q  <= mem_id_d;
    mem_res_q <= mem_res_d;
  end

  // The pointers wrap by compare-and-reset, so depths that are not a power
  // of two work as well.
  always_comb begin
    prio_d = prio_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      prio_d = (gnt_idx == LAST_ID) ? '0 : gnt_idx + IdW'(1);
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      prio_q <= prio_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rsp_valid_o  = (cnt_q != '0);
  assign rsp_id_o     = mem_id_q[rptr_q];
  assign rsp_result_o = mem_res_q[rptr_q];

endmodule

// File: tb/tb_panda_alu_arbiter.sv
// Bench for panda_alu_arbiter with NumReq = 2 and RspDepth = 2. A behavioural
// ALU stands in for panda_alu. A reference model keeps a response queue and
// an integer priority, then predicts grants, ALU drive and FIFO head every
// cycle.
module tb_panda_alu_arbiter;
  localparam int N   = 2;
  localparam int D   = 2;
  localparam int OPW = 4;

  localparam logic [OPW-1:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2,
                             ALU_OR  = 4'd3, ALU_AND = 4'd4, ALU_SLL = 4'd5,
                             ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_LT  = 4'd8,
                             ALU_LTU = 4'd9;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   valid;
  logic [N-1:0]   ready;
  logic [OPW-1:0] op  [N];
  logic [31:0]    opa [N];
  logic [31:0]    opb [N];
  logic [N*OPW-1:0] op_flat;
  logic [N*32-1:0]  a_flat, b_flat;
  logic           rsp_valid, rsp_ready;
  logic [0:0]     rsp_id;
  logic [31:0]    rsp_result;
  logic [OPW-1:0] alu_op;
  logic [31:0]    alu_a, alu_b, alu_res;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [OPW-1:0] o,
                                         input logic [31:0] a, input logic [31:0] b);
    case (o)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_XOR: return a ^ b;
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return 32'($signed(a) >>> b[4:0]);
      ALU_LT:  return {31'd0, ($signed(a) < $signed(b))};
      ALU_LTU: return {31'd0, (a < b)};
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    op_flat = '0;
    a_flat  = '0;
    b_flat  = '0;
    for (int r = 0; r < N; r++) begin
      op_flat[r*OPW +: OPW] = op[r];
      a_flat[r*32 +: 32]    = opa[r];
      b_flat[r*32 +: 32]    = opb[r];
    end
  end

  always_comb alu_res = alu_fn(alu_op, alu_a, alu_b);

  panda_alu_arbiter #(.NumReq(N), .RspDepth(D), .OpW(OPW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_operator_i(op_flat), .req_operand_a_i(a_flat), .req_operand_b_i(b_flat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_result_o(rsp_result),
    .alu_operator_o(alu_op), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
    .alu_result_i(alu_res)
  );

  typedef struct {
    int          id;
    logic [31:0] res;
  } rsp_t;

  rsp_t        mq[$];
  int          prio_m;
  int          n_chk;
  int          n_fail;
  logic [N-1:0] obs_rdy;
  logic        obs_valid;
  logic [0:0]  obs_id;
  logic [31:0] obs_res;
  logic [N-1:0] acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic [OPW-1:0] o,
                         input logic [31:0] a, input logic [31:0] b);
    valid[r] = v;
    op[r]    = o;
    opa[r]   = a;
    opb[r]   = b;
  endtask

  task automatic rnd_req(input int r);
    op[r]  = OPW'($urandom_range(0, 9));
    opa[r] = $urandom;
    opb[r] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
  endtask

  // One clock cycle: check at the negedge against the model, then advance
  // the model at the posedge.
  task automatic step();
    int           g;
    int           r;
    logic [N-1:0] exp_rdy;
    logic [31:0]  exp_res;
    @(negedge clk);
    g = -1;
    if (!rst && mq.size() < D) begin
      for (int k = 0; k < N; k++) begin
        r = (prio_m + k) % N;
        if (g < 0 && valid[r]) g = r;
      end
    end
    exp_rdy = '0;
    exp_res = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      exp_res    = alu_fn(op[g], opa[g], opb[g]);
    end
    obs_rdy   = ready;
    obs_valid = rsp_valid;
    obs_id    = rsp_id;
    obs_res   = rsp_result;
    chk("req_ready", ready, exp_rdy);
    chk("alu_op", alu_op, (g >= 0) ? op[g] : ALU_ADD);
    chk("alu_a", alu_a, (g >= 0) ? opa[g] : 32'd0);
    chk("alu_b", alu_b, (g >= 0) ? opb[g] : 32'd0);
    chk("rsp_valid", rsp_valid, (mq.size() != 0));
    if (mq.size() != 0) begin
      chk("rsp_id", rsp_id, mq[0].id);
      chk("rsp_result", rsp_result, mq[0].res);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      prio_m = 0;
      acc    = '0;
    end else begin
      if (mq.size() != 0 && rsp_ready) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back('{id: g, res: exp_res});
        prio_m = (g + 1) % N;
      end
      acc = exp_rdy;
    end
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    prio_m = 0;
    acc = '0;
    valid = '0;
    rsp_ready = 1'b0;
    rst = 1'b1;

    // Reset held for 3 cycles with every requester valid
    set_req(0, 1'b1, ALU_SUB, 32'd5, 32'd7);
    set_req(1, 1'b1, ALU_SLL, 32'd1, 32'd31);
    repeat (3) begin
      step();
      chk("rst_ready", obs_rdy, 2'b00);
      chk("rst_rsp_valid", obs_valid, 1'b0);
    end

    // First grant after reset, one-cycle latency, round-robin alternation
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("first_gnt", obs_rdy, 2'b01);
    step();
    chk("rr_gnt1", obs_rdy, 2'b10);
    chk("lat_valid", obs_valid, 1'b1);
    chk("sub_id", obs_id, 1'b0);
    chk("sub_res", obs_res, 32'hFFFF_FFFE);
    step();
    chk("rr_gnt0", obs_rdy, 2'b01);
    chk("sll_id", obs_id, 1'b1);
    chk("sll_res", obs_res, 32'h8000_0000);
    step();
    chk("rr_gnt1b", obs_rdy, 2'b10);
    valid = '0;
    repeat (3) step();
    chk("drained", obs_valid, 1'b0);

    // Full FIFO: two accepts, stall, no pass-through on the pop cycle
    rsp_ready = 1'b0;
    set_req(0, 1'b1, ALU_ADD, 32'd10, 32'd20);
    step();
    chk("full_acc1", obs_rdy, 2'b01);
    rnd_req(0);
    step();
    chk("full_acc2", obs_rdy, 2'b01);
    rnd_req(0);
    step();
    chk("full_stall", obs_rdy, 2'b00);
    rsp_ready = 1'b1;
    step();
    chk("no_passthru", obs_rdy, 2'b00);
    chk("full_head_res", obs_res, 32'd30);
    rsp_ready = 1'b0;
    step();
    chk("after_pop_acc", obs_rdy, 2'b01);
    valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();

    // Simultaneous push and pop at count = 1, including signed/unsigned compares
    set_req(0, 1'b1, ALU_LT, 32'hFFFF_FFFF, 32'd1);
    step();
    set_req(0, 1'b1, ALU_LTU, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("lt_res", obs_res, 32'd1);
    chk("pp_ready0", obs_rdy, 2'b01);
    rnd_req(0);
    step();
    chk("ltu_res", obs_res, 32'd0);
    for (int i = 0; i < 10; i++) begin
      rnd_req(0);
      step();
      chk("pp_ready", obs_rdy, 2'b01);
      chk("pp_valid", obs_valid, 1'b1);
    end
    valid = '0;
    repeat (3) step();

    // Reset with two entries buffered and prio moved to requester 1
    rsp_ready = 1'b0;
    valid[0] = 1'b1;
    rnd_req(0);
    step();
    rnd_req(0);
    step();
    valid = '0;
    rst = 1'b1;
    step();
    chk("midrst_ready", obs_rdy, 2'b00);
    rst = 1'b0;
    valid = 2'b11;
    rnd_req(0);
    rnd_req(1);
    step();
    chk("midrst_empty", obs_valid, 1'b0);
    chk("midrst_prio", obs_rdy, 2'b01);

    // Randomised traffic; unaccepted requests hold their payload
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < N; r++) begin
        if (acc[r] || !valid[r]) begin
          valid[r] = ($urandom_range(0, 3) != 0);
          rnd_req(r);
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
